// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem req/ack, IF/ID slot with valid/ready.
// Define IF_MISALIGN_TRAP_EN to trap on misaligned redirects instead of forcing the low PC bits to 00.
module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [5:0]      opcode,
  output logic [9:0]      xox,
  output logic [8:0]      xoxo,
  output logic [1:0]      xods,
  output logic            fetch_fault
);

`ifdef IF_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {BOOT, REQ, HOLD, DRAIN, TRAP} state_t;
`else
  typedef enum logic [2:0] {BOOT, REQ, HOLD, DRAIN} state_t;
`endif

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_addr;
  logic [PC_W-1:0] target;

  assign target    = {redirect_pc[PC_W-1:2], 2'b00};
  assign imem_addr = req_addr;

  assign opcode = id_instr[31:26];
  assign xox    = id_instr[10:1];
  assign xoxo   = id_instr[9:1];
  assign xods   = id_instr[1:0];

`ifdef IF_MISALIGN_TRAP_EN
  logic misaligned;
  logic trap_pend;
  logic fault_q;

  assign misaligned  = redirect_pc[1:0] != 2'b00;
  assign fetch_fault = fault_q;
`else
  logic unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];
  assign fetch_fault     = 1'b0;
`endif

  // A redirect while a request is in flight cannot cancel it on the bus, so DRAIN
  // keeps the stale request up until its ack and then restarts at the newest target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      imem_req <= 1'b0;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
`ifdef IF_MISALIGN_TRAP_EN
      trap_pend <= 1'b0;
      fault_q   <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: begin
          state    <= REQ;
          imem_req <= 1'b1;
          req_addr <= pc;
        end

        REQ: begin
          if (redirect) begin
`ifdef IF_MISALIGN_TRAP_EN
            if (misaligned) begin
              if (imem_ack) begin
                state    <= TRAP;
                imem_req <= 1'b0;
                fault_q  <= 1'b1;
              end else begin
                trap_pend <= 1'b1;
                state     <= DRAIN;
              end
            end else
`endif
            begin
              pc <= target;
              if (imem_ack) begin
                req_addr <= target;
              end else begin
                state <= DRAIN;
              end
            end
          end else if (imem_ack) begin
            id_instr <= imem_rdata;
            id_pc    <= req_addr;
            id_valid <= 1'b1;
            pc       <= req_addr + PC_W'(4);
            imem_req <= 1'b0;
            state    <= HOLD;
          end
        end

        HOLD: begin
          if (redirect) begin
            id_valid <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            if (misaligned) begin
              state   <= TRAP;
              fault_q <= 1'b1;
            end else
`endif
            begin
              pc       <= target;
              req_addr <= target;
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end else if (id_ready) begin
            id_valid <= 1'b0;
            req_addr <= pc;
            imem_req <= 1'b1;
            state    <= REQ;
          end
        end

        DRAIN: begin
`ifdef IF_MISALIGN_TRAP_EN
          if (trap_pend || (redirect && misaligned)) begin
            trap_pend <= 1'b1;
            if (imem_ack) begin
              trap_pend <= 1'b0;
              imem_req  <= 1'b0;
              fault_q   <= 1'b1;
              state     <= TRAP;
            end
          end else
`endif
          begin
            if (redirect) begin
              pc <= target;
            end
            if (imem_ack) begin
              req_addr <= redirect ? target : pc;
              state    <= REQ;
            end
          end
        end

`ifdef IF_MISALIGN_TRAP_EN
        TRAP: begin
          imem_req <= 1'b0;
          id_valid <= 1'b0;
          fault_q  <= 1'b1;
        end
`endif

        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
          id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
